// File: rtl/tx_xgmii_encoder_if.sv
// FIFO-read and XGMII TX signal bundle for tx_xgmii_encoder.
// The master side is the encoder; the slave side is the FIFO/PHY environment.
interface tx_xgmii_encoder_if;
    logic [63:0] txhfifo_rdata;
    logic [7:0]  txhfifo_rstatus;
    logic        txhfifo_rempty;
    logic        txhfifo_ren;
    logic [63:0] xgmii_txd;
    logic [7:0]  xgmii_txc;
    logic        stat_tx_frame;
    logic        stat_tx_underrun;
    logic        stat_tx_framing_err;

    modport master (
        input  txhfifo_rdata, txhfifo_rstatus, txhfifo_rempty,
        output txhfifo_ren, xgmii_txd, xgmii_txc,
        output stat_tx_frame, stat_tx_underrun, stat_tx_framing_err
    );

    modport slave (
        output txhfifo_rdata, txhfifo_rstatus, txhfifo_rempty,
        input  txhfifo_ren, xgmii_txd, xgmii_txc,
        input  stat_tx_frame, stat_tx_underrun, stat_tx_framing_err
    );
endinterface

// File: rtl/tx_xgmii_encoder.sv
// Pops frame words from the TX hold FIFO and frames them onto the 64-bit XGMII TX bus,
// inserting start/preamble, terminate and idle while enforcing the inter-packet gap.
module tx_xgmii_encoder #(
    parameter int unsigned IPG_BYTES = 12
) (
    input logic                  clk_xgmii_tx,
    input logic                  reset_xgmii_tx,
    tx_xgmii_encoder_if.master   bus
);
    localparam logic [63:0] IDLE_D = 64'h0707070707070707;
    localparam logic [7:0]  IDLE_C = 8'hFF;
    localparam logic [63:0] PRE_D  = 64'hD5555555555555FB;
    localparam logic [7:0]  PRE_C  = 8'h01;
    localparam logic [63:0] ERR_D  = 64'hFEFEFEFEFEFEFEFE;
    localparam logic [7:0]  ERR_C  = 8'hFF;
    localparam logic [63:0] TERM_D = 64'h07070707070707FD;
    localparam logic [7:0]  TERM_C = 8'hFF;
    localparam logic [4:0]  IPG_MIN = 5'(IPG_BYTES);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_TERM, S_DRAIN} state_t;

    state_t      state;
    logic [63:0] txd_q;
    logic [7:0]  txc_q;
    logic        frame_q, underrun_q, framing_err_q;
    logic [4:0]  ipg_cnt;
    logic [4:0]  ipg_inc;
    logic        ren_c;
    logic        sop, eop;
    logic [2:0]  n_bytes;
    logic [63:0] term_d;
    logic [7:0]  term_c;
    logic        unused_status_bits;

    assign sop     = bus.txhfifo_rstatus[7];
    assign eop     = bus.txhfifo_rstatus[6];
    assign n_bytes = bus.txhfifo_rstatus[2:0];
    assign unused_status_bits = ^bus.txhfifo_rstatus[5:3];

    assign ipg_inc = (ipg_cnt > 5'd23) ? 5'd31 : ipg_cnt + 5'd8;

    // Partial last word: data bytes, then terminate, then idle fill (n=1..7 only).
    always_comb begin
        term_d = '0;
        term_c = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (i < 32'(n_bytes)) begin
                term_d[8*i +: 8] = bus.txhfifo_rdata[8*i +: 8];
                term_c[i]        = 1'b0;
            end else if (i == 32'(n_bytes)) begin
                term_d[8*i +: 8] = 8'hFD;
                term_c[i]        = 1'b1;
            end else begin
                term_d[8*i +: 8] = 8'h07;
                term_c[i]        = 1'b1;
            end
        end
    end

    // Pop is gated by reset so a frame abandoned by reset keeps its remaining words queued.
    always_comb begin
        ren_c = 1'b0;
        if (!reset_xgmii_tx && !bus.txhfifo_rempty) begin
            case (state)
                S_IDLE:          ren_c = !sop;
                S_DATA, S_DRAIN: ren_c = 1'b1;
                default:         ren_c = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_xgmii_tx) begin
        if (reset_xgmii_tx) begin
            state         <= S_IDLE;
            txd_q         <= IDLE_D;
            txc_q         <= IDLE_C;
            frame_q       <= 1'b0;
            underrun_q    <= 1'b0;
            framing_err_q <= 1'b0;
            ipg_cnt       <= IPG_MIN;
        end else begin
            frame_q       <= 1'b0;
            underrun_q    <= 1'b0;
            framing_err_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    txd_q   <= IDLE_D;
                    txc_q   <= IDLE_C;
                    ipg_cnt <= ipg_inc;
                    if (!bus.txhfifo_rempty) begin
                        if (!sop) begin
                            framing_err_q <= 1'b1;
                        end else if (ipg_cnt >= IPG_MIN) begin
                            txd_q <= PRE_D;
                            txc_q <= PRE_C;
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (bus.txhfifo_rempty) begin
                        txd_q      <= ERR_D;
                        txc_q      <= ERR_C;
                        underrun_q <= 1'b1;
                        ipg_cnt    <= '0;
                        state      <= S_DRAIN;
                    end else if (!eop || n_bytes == 3'd0) begin
                        txd_q <= bus.txhfifo_rdata;
                        txc_q <= '0;
                        if (eop) state <= S_TERM;
                    end else begin
                        txd_q   <= term_d;
                        txc_q   <= term_c;
                        ipg_cnt <= 5'd8 - {2'b00, n_bytes};
                        frame_q <= 1'b1;
                        state   <= S_IDLE;
                    end
                end
                S_TERM: begin
                    txd_q   <= TERM_D;
                    txc_q   <= TERM_C;
                    ipg_cnt <= 5'd8;
                    frame_q <= 1'b1;
                    state   <= S_IDLE;
                end
                S_DRAIN: begin
                    txd_q   <= IDLE_D;
                    txc_q   <= IDLE_C;
                    ipg_cnt <= ipg_inc;
                    if (!bus.txhfifo_rempty && eop) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.txhfifo_ren         = ren_c;
    assign bus.xgmii_txd           = txd_q;
    assign bus.xgmii_txc           = txc_q;
    assign bus.stat_tx_frame       = frame_q;
    assign bus.stat_tx_underrun    = underrun_q;
    assign bus.stat_tx_framing_err = framing_err_q;
endmodule
